// File: rtl/cpu_ram_banked_if.sv
// CPU memory-port bus for cpu_ram_banked: valid/ready request with byte-masked writes.
// The CPU side uses the master modport and the RAM uses the slave modport.
interface cpu_ram_banked_if #(
  parameter int ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  valid;
  logic                  write_en;
  logic [3:0]            wstrb;
  logic [31:0]           write_data;
  logic                  ready;
  logic [31:0]           read_data;

  modport master (
    output address, valid, write_en, wstrb, write_data,
    input  ready, read_data
  );

  modport slave (
    input  address, valid, write_en, wstrb, write_data,
    output ready, read_data
  );
endinterface

// File: rtl/cpu_ram_banked.sv
// Banked CPU RAM: BANKS x 16K x 32 words, each bank built from two 16-bit SPRAMs, behind a
// valid/ready handshake. Optional per-bank idle sleep is enabled by defining CPU_RAM_SLEEP_EN.

// Behavioural stand-in for one SB_SPRAM256KA (16K x 16, nibble write mask, registered output).
module cpu_ram_spram (
  input  logic        clk,
  input  logic [13:0] i_address,
  input  logic [15:0] i_datain,
  input  logic [3:0]  i_maskwren,
  input  logic        i_wren,
  input  logic        i_chipselect,
  input  logic        i_standby,
  input  logic        i_sleep,
  input  logic        i_poweroff,
  output logic [15:0] o_dataout
);
  logic [15:0] r_mem [0:16383];
  logic        w_enable;

  assign w_enable = i_chipselect && !i_standby && !i_sleep && i_poweroff;

  // NOTE: the array and its output register have no reset; RAM contents must survive reset_n.
  always_ff @(posedge clk) begin
    if (w_enable) begin
      if (i_wren) begin
        for (int n = 0; n < 4; n++) begin
          if (i_maskwren[n]) r_mem[i_address][4*n +: 4] <= i_datain[4*n +: 4];
        end
      end else begin
        o_dataout <= r_mem[i_address];
      end
    end
  end
endmodule

module cpu_ram_banked #(
  parameter int BANKS             = 2,
  parameter int SLEEP_IDLE_CYCLES = 256,
  parameter int WAKE_CYCLES       = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  cpu_ram_banked_if.slave  bus
);
  localparam int ADDR_WIDTH = 14 + $clog2(BANKS);
  localparam int BANK_W     = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int WAKE_W     = $clog2(WAKE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAKE, S_ACCESS} state_t;

  generate
    if (SLEEP_IDLE_CYCLES < 1 || WAKE_CYCLES < 1) begin : g_bad_param
      $error("cpu_ram_banked: SLEEP_IDLE_CYCLES and WAKE_CYCLES must be >= 1");
    end
  endgenerate

  state_t              r_state, w_state_nxt;
  logic [BANK_W-1:0]   w_bank, r_bank_sel;
  logic                r_was_write;
  logic [WAKE_W-1:0]   r_wake_cnt;
  logic                w_issue, w_wake_start, w_tgt_asleep;
  logic [BANKS-1:0]    w_cs, w_sleep;
  logic [31:0]         w_dout [BANKS];
  logic [7:0]          w_mask;

  generate
    if (BANKS > 1) begin : g_bank_sel
      assign w_bank = bus.address[ADDR_WIDTH-1:14];
    end else begin : g_one_bank
      assign w_bank = '0;
    end
  endgenerate

  assign w_tgt_asleep = w_sleep[w_bank];

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_wake_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.valid) begin
          if (w_tgt_asleep) begin
            w_wake_start = 1'b1;
            w_state_nxt  = S_WAKE;
          end else begin
            w_issue     = 1'b1;
            w_state_nxt = S_ACCESS;
          end
        end
      end
      S_WAKE: begin
        if (r_wake_cnt == '0) begin
          w_issue     = bus.valid;
          w_state_nxt = bus.valid ? S_ACCESS : S_IDLE;
        end
      end
      S_ACCESS: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_bank_sel  <= '0;
      r_was_write <= 1'b0;
      r_wake_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_bank_sel  <= w_bank;
        r_was_write <= bus.write_en;
      end
      if (w_wake_start) begin
        r_wake_cnt <= WAKE_W'(WAKE_CYCLES);
      end else if (r_state == S_WAKE && r_wake_cnt != '0) begin
        r_wake_cnt <= r_wake_cnt - WAKE_W'(1);
      end
    end
  end

`ifdef CPU_RAM_SLEEP_EN
  localparam int IDLE_W = $clog2(SLEEP_IDLE_CYCLES + 1);

  logic [IDLE_W-1:0] r_idle_cnt [BANKS];
  logic [BANKS-1:0]  r_sleep;

  // A bank being woken or accessed keeps its idle count at zero so it cannot re-sleep mid-wake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < BANKS; b++) r_idle_cnt[b] <= '0;
      r_sleep <= '0;
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (w_cs[b] || (w_bank == BANK_W'(b) && (w_wake_start || r_state == S_WAKE))) begin
          r_idle_cnt[b] <= '0;
          r_sleep[b]    <= 1'b0;
        end else if (r_idle_cnt[b] == IDLE_W'(SLEEP_IDLE_CYCLES)) begin
          r_sleep[b] <= 1'b1;
        end else begin
          r_idle_cnt[b] <= r_idle_cnt[b] + IDLE_W'(1);
        end
      end
    end
  end

  assign w_sleep = r_sleep;
`else
  assign w_sleep = '0;
`endif

  assign w_mask = {{2{bus.wstrb[3]}}, {2{bus.wstrb[2]}}, {2{bus.wstrb[1]}}, {2{bus.wstrb[0]}}};

  generate
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
      assign w_cs[b] = w_issue && (w_bank == BANK_W'(b));

      cpu_ram_spram u_lo (
        .clk          (clk),
        .i_address    (bus.address[13:0]),
        .i_datain     (bus.write_data[15:0]),
        .i_maskwren   (w_mask[3:0]),
        .i_wren       (bus.write_en),
        .i_chipselect (w_cs[b]),
        .i_standby    (1'b0),
        .i_sleep      (w_sleep[b]),
        .i_poweroff   (1'b1),
        .o_dataout    (w_dout[b][15:0])
      );

      cpu_ram_spram u_hi (
        .clk          (clk),
        .i_address    (bus.address[13:0]),
        .i_datain     (bus.write_data[31:16]),
        .i_maskwren   (w_mask[7:4]),
        .i_wren       (bus.write_en),
        .i_chipselect (w_cs[b]),
        .i_standby    (1'b0),
        .i_sleep      (w_sleep[b]),
        .i_poweroff   (1'b1),
        .o_dataout    (w_dout[b][31:16])
      );
    end
  endgenerate

  assign bus.ready     = (r_state == S_ACCESS);
  assign bus.read_data = (bus.ready && !r_was_write) ? w_dout[r_bank_sel] : 32'h0;
endmodule

// File: tb/tb_cpu_ram_banked.sv
// Self-checking bench for cpu_ram_banked: scoreboard of expected read data, per-scenario tasks.
// Build with +define+CPU_RAM_SLEEP_EN to exercise the sleep/wake path.
module tb_cpu_ram_banked;
  localparam int BANKS = 2;
  localparam int AW    = 15;
`ifdef CPU_RAM_SLEEP_EN
  localparam int SLEEP_IDLE = 8;
  localparam int WAKE       = 3;
  localparam int LAT_ANY    = -1;
  localparam int LAT_SLEPT  = 2 + WAKE;
`else
  localparam int SLEEP_IDLE = 256;
  localparam int WAKE       = 3;
  localparam int LAT_ANY    = 1;
  localparam int LAT_SLEPT  = 1;
`endif

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] sb_q [$];

  cpu_ram_banked_if #(.ADDR_WIDTH(AW)) bus ();

  cpu_ram_banked #(
    .BANKS             (BANKS),
    .SLEEP_IDLE_CYCLES (SLEEP_IDLE),
    .WAKE_CYCLES       (WAKE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete transaction; exp_lat <= 0 leaves the latency unchecked.
  task automatic access(input logic we, input logic [AW-1:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] exp_rd, input int exp_lat,
                        input string name);
    int lat;
    logic [31:0] exp;
    @(negedge clk);
    bus.address    = a;
    bus.write_en   = we;
    bus.wstrb      = s;
    bus.write_data = d;
    bus.valid      = 1'b1;
    sb_q.push_back(we ? 32'h0 : exp_rd);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.ready && lat < 40);
    bus.valid = 1'b0;
    exp = sb_q.pop_front();
    n_checks++;
    if (!bus.ready) begin
      n_fail++;
      $display("FAIL %s_timeout: no ready after %0d cycles, required ready=1", name, lat);
    end else begin
      if (exp_lat > 0) begin
        n_checks++;
        if (lat != exp_lat) begin
          n_fail++;
          $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, exp_lat);
        end
      end
      n_checks++;
      if (bus.read_data !== exp) begin
        n_fail++;
        $display("FAIL %s_data: got %h, required %h", name, bus.read_data, exp);
      end
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.valid      = 1'b0;
    bus.write_en   = 1'b0;
    bus.wstrb      = 4'h0;
    bus.write_data = 32'h0;
    bus.address    = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 0", bus.ready);
    end
    n_checks++;
    if (bus.read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_read_data: got %h, required 0", bus.read_data);
    end
    n_checks++;
    if (dut.w_sleep !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_sleep: got %b, required 00", dut.w_sleep);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b0 || bus.read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_outputs: got ready=%b data=%h, required 0/0", bus.ready, bus.read_data);
    end
  endtask

  task automatic test_basic();
    access(1'b1, 15'h0010, 4'hF, 32'hDEADBEEF, 32'h0, 1, "basic_wr");
    access(1'b0, 15'h0010, 4'h0, 32'h0, 32'hDEADBEEF, 1, "basic_rd");
  endtask

  task automatic test_wstrb();
    access(1'b1, 15'h0010, 4'h5, 32'h11223344, 32'h0, 1, "strb5_wr");
    access(1'b0, 15'h0010, 4'h0, 32'h0, 32'hDE22BE44, 1, "strb5_rd");
    access(1'b1, 15'h0010, 4'h0, 32'hFFFFFFFF, 32'h0, 1, "strb0_wr");
    access(1'b0, 15'h0010, 4'h0, 32'h0, 32'hDE22BE44, 1, "strb0_rd");
  endtask

  task automatic test_banks();
    access(1'b1, 15'h0000, 4'hF, 32'hA5A5A5A5, 32'h0, 1, "bank0_wr");
    access(1'b1, 15'h4000, 4'hF, 32'h5A5A5A5A, 32'h0, LAT_ANY, "bank1_wr");
    access(1'b0, 15'h0000, 4'h0, 32'h0, 32'hA5A5A5A5, 1, "bank0_rd");
    access(1'b0, 15'h4000, 4'h0, 32'h0, 32'h5A5A5A5A, 1, "bank1_rd");
    access(1'b0, 15'h0010, 4'h0, 32'h0, 32'hDE22BE44, 1, "bank0_keep_rd");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [6];
    logic [31:0]   vals  [6];
    int idx, last_c;
    for (int i = 0; i < 6; i++) begin
      addrs[i] = (i % 2 == 1) ? AW'(15'h4100 + i) : AW'(15'h0100 + i);
      vals[i]  = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      access(1'b1, addrs[i], 4'hF, vals[i], 32'h0, (i < 2) ? LAT_ANY : 1, "b2b_fill");
    end
    for (int i = 0; i < 6; i++) sb_q.push_back(vals[i]);
    @(negedge clk);
    bus.write_en = 1'b0;
    bus.address  = addrs[0];
    bus.valid    = 1'b1;
    idx    = 0;
    last_c = -2;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      @(negedge clk);
      if (bus.ready) begin
        logic [31:0] exp;
        exp = sb_q.pop_front();
        n_checks++;
        if (c - last_c != 2) begin
          n_fail++;
          $display("FAIL b2b_spacing: pulse %0d came %0d cycles after previous, required 2", idx, c - last_c);
        end
        n_checks++;
        if (bus.read_data !== exp) begin
          n_fail++;
          $display("FAIL b2b_data: pulse %0d got %h, required %h", idx, bus.read_data, exp);
        end
        last_c = c;
        idx++;
        if (idx < 6) bus.address = addrs[idx];
        else bus.valid = 1'b0;
      end else begin
        n_checks++;
        if (bus.read_data !== 32'h0) begin
          n_fail++;
          $display("FAIL b2b_gap_data: got %h while ready=0, required 0", bus.read_data);
        end
      end
    end
    bus.valid = 1'b0;
    n_checks++;
    if (idx != 6) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d ready pulses, required 6", idx);
      sb_q.delete();
    end
  endtask

  task automatic test_sleep();
    repeat (10) @(negedge clk);
    n_checks++;
`ifdef CPU_RAM_SLEEP_EN
    if (dut.w_sleep[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sleep_entered: got %b, required 1", dut.w_sleep[0]);
    end
`else
    if (dut.w_sleep[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sleep_disabled: got %b, required 0", dut.w_sleep[0]);
    end
`endif
    access(1'b0, 15'h0010, 4'h0, 32'h0, 32'hDE22BE44, LAT_SLEPT, "wake_rd");
    n_checks++;
    if (dut.w_sleep[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sleep_woken: got %b, required 0", dut.w_sleep[0]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.address    = 15'h0020;
    bus.write_en   = 1'b1;
    bus.wstrb      = 4'hF;
    bus.write_data = 32'hCAFEF00D;
    bus.valid      = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre_ready: got %b, required 1", bus.ready);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_ready: got %b, required 0", bus.ready);
    end
    bus.valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    access(1'b0, 15'h0020, 4'h0, 32'h0, 32'hCAFEF00D, 1, "mid_reset_rd");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wstrb();
    test_banks();
    test_back_to_back();
    test_sleep();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
